// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and line/parity constants for the UART transmit controller
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter; tick_o marks the last cycle of each UART bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame controller (start, data via Serializer, parity, stop)
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_TYP,
`endif
  input  logic                  SER_DATA,
  input  logic                  SER_DONE,
  output logic                  SER_EN,
  output logic                  SER_STEP,
  output logic [DATA_WIDTH-1:0] SER_PDATA,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  SER_ERR
);

  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  err_q, err_d;
  logic                  baud_clr, baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .CLK    (CLK),
    .RST    (RST),
    .clr_i  (baud_clr),
    .en_i   (state_q != IDLE),
    .tick_o (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    pdata_d   = pdata_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
    baud_clr  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_d   = START;
          pdata_d   = P_DATA;
          bit_cnt_d = '0;
          baud_clr  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
`endif
        end
      end
      START: begin
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        // The bit counter alone ends the data phase; SER_DONE is only audited here.
        if (baud_tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            if (!SER_DONE) err_d = 1'b1;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      pdata_q   <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pdata_q   <= pdata_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Line mux decodes registered state only, so reset forces the line high at once.
  always_comb begin
    TX_OUT = LINE_IDLE;
    case (state_q)
      START:  TX_OUT = START_BIT;
      DATA:   TX_OUT = SER_DATA;
`ifdef UART_TX_PARITY_EN
      PARITY: TX_OUT = parity_q;
`endif
      STOP:   TX_OUT = STOP_BIT;
      default: TX_OUT = LINE_IDLE;
    endcase
  end

  assign BUSY      = (state_q != IDLE);
  assign SER_EN    = (state_q == DATA);
  assign SER_STEP  = (state_q == DATA) && baud_tick;
  assign SER_PDATA = pdata_q;
  assign SER_ERR   = err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized self-checking bench with a frame-level reference model
module tb_uart_tx_ctrl;

  localparam int DW = 8;
  localparam int C  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FLEN = NBITS * C;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          par_typ = 1'b0;
  logic          SER_DATA, SER_DONE;
  logic          SER_EN, SER_STEP, TX_OUT, BUSY, SER_ERR;
  logic [DW-1:0] SER_PDATA;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
`ifdef UART_TX_PARITY_EN
    .PAR_TYP    (par_typ),
`endif
    .SER_DATA   (SER_DATA),
    .SER_DONE   (SER_DONE),
    .SER_EN     (SER_EN),
    .SER_STEP   (SER_STEP),
    .SER_PDATA  (SER_PDATA),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .SER_ERR    (SER_ERR)
  );

  always #5 CLK = ~CLK;

  // Serializer stand-in: 0 = honest, 1 = SER_DONE stuck low, 2 = SER_DONE stuck high
  int done_mode = 0;
  int idx = 0;
  always @(posedge CLK or posedge RST) begin
    if (RST)            idx <= 0;
    else if (!SER_EN)   idx <= 0;
    else if (SER_STEP)  idx <= idx + 1;
  end
  assign SER_DATA = (idx < DW) ? SER_PDATA[idx[2:0]] : 1'b0;
  assign SER_DONE = (done_mode == 1) ? 1'b0 : (done_mode == 2) ? 1'b1 : (idx == DW - 1);

  // Frame model: pos = cycles since the accepting edge, -1 when idle
  int            pos = -1;
  logic [DW-1:0] mbyte = '0;
  logic          mpar = 1'b0;
  logic          merr = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      pos = -1; merr = 1'b0; mbyte = '0;
    end else if (pos < 0) begin
      if (DATA_VALID) begin
        pos = 0; mbyte = P_DATA; mpar = (^P_DATA) ^ par_typ;
      end
    end else begin
      if (pos == (1 + DW) * C - 1 && done_mode == 1) merr = 1'b1;
      pos++;
      if (pos == FLEN) pos = -1;
    end
  end

  function automatic logic exp_bit(int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return mbyte[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == DW + 1) return mpar;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      int  b;
      logic in_data;
      b = pos / C;
      in_data = (pos >= 0) && (b >= 1) && (b <= DW);
      chk("tx_out",    TX_OUT,    (pos < 0) ? 1'b1 : exp_bit(b));
      chk("busy",      BUSY,      pos >= 0);
      chk("ser_en",    SER_EN,    in_data);
      chk("ser_step",  SER_STEP,  in_data && (pos % C == C - 1));
      chk("ser_err",   SER_ERR,   merr);
      chk("ser_pdata", SER_PDATA, mbyte);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (pos >= 0 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (pos >= 0) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pt);
    @(negedge CLK);
    P_DATA = d; par_typ = pt; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  initial begin
    logic txs [0:63];
    logic [NBITS-1:0] lit;
    int busy_cnt, step_cnt;

    repeat (3) @(negedge CLK);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_en", SER_EN, 0);
    chk("rst_step", SER_STEP, 0);
    chk("rst_pdata", SER_PDATA, 0);
    chk("rst_err", SER_ERR, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Basic frame 8'hA5 with bit-by-bit literal expectations
    @(negedge CLK);
    P_DATA = 8'hA5; par_typ = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    busy_cnt = 0; step_cnt = 0;
    for (int k = 0; k < 48; k++) begin
      txs[k] = TX_OUT;
      busy_cnt += int'(BUSY);
      step_cnt += int'(SER_STEP);
      @(negedge CLK);
    end
`ifdef UART_TX_PARITY_EN
    lit = 11'b1_0_10100101_0;
    chk("a5_busy_len", busy_cnt, 44);
`else
    lit = 10'b1_10100101_0;
    chk("a5_busy_len", busy_cnt, 40);
`endif
    for (int b = 0; b < NBITS; b++) chk("a5_bit", txs[b*C+2], lit[b]);
    chk("a5_steps", step_cnt, 8);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1'b0);
    busy_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      txs[k] = TX_OUT;
      busy_cnt += int'(BUSY);
      @(negedge CLK);
    end
    chk("par_even_bit", txs[9*C+1], 1'b1);
    chk("par_even_len", busy_cnt, 44);
    send(8'h07, 1'b1);
    for (int k = 0; k < 50; k++) begin
      txs[k] = TX_OUT;
      @(negedge CLK);
    end
    chk("par_odd_bit", txs[9*C+1], 1'b0);
`endif

    // Back-to-back with P_DATA changing while busy
    @(negedge CLK);
    P_DATA = 8'h00; DATA_VALID = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hFF;
    repeat (FLEN) @(negedge CLK);
    chk("b2b_gap_busy", BUSY, 0);
    chk("b2b_gap_tx", TX_OUT, 1);
    @(negedge CLK);
    chk("b2b_second_busy", BUSY, 1);
    chk("b2b_second_tx", TX_OUT, 0);
    DATA_VALID = 1'b0;
    P_DATA = 8'h3C;
    repeat (C + 2) @(negedge CLK);
    chk("b2b_ff_bit0", TX_OUT, 1);
    wait_idle();

    // Reset during data bit 3
    send(8'h5A, 1'b0);
    repeat (4 * C) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_tx", TX_OUT, 1);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_en", SER_EN, 0);
    @(negedge CLK);
    RST = 1'b0;
    send(8'hC3, 1'b1);
    wait_idle();

    // Serializer fault: SER_DONE never asserted
    done_mode = 1;
    send(8'h96, 1'b0);
    wait_idle();
    done_mode = 0;
    chk("fault_err_set", SER_ERR, 1);
    send(8'h11, 1'b0);
    wait_idle();
    chk("fault_err_sticky", SER_ERR, 1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("fault_err_clear", SER_ERR, 0);

    // Randomized frames, gaps and early-SER_DONE serializers
    for (int f = 0; f < 20; f++) begin
      done_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      send(DW'($urandom), 1'($urandom));
      P_DATA = DW'($urandom);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    done_mode = 0;
    repeat (4) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmit path. Accepts a parallel byte through a valid/busy handshake, generates the bit-period timing, and sequences the frame start → data (via the `Serializer`) → optional parity → stop. It muxes the line itself and drives `TX_OUT`. It sits between the host-side byte source and the pad; the `Serializer` is a slave of this block.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `CLKS_PER_BIT`, 16, `CLK` cycles per UART bit period (≥2).
- `CLK` input 1: single clock, all logic rising-edge.
- `RST` input 1: asynchronous, active-high reset.
- `P_DATA` input `DATA_WIDTH`: byte to send, sampled on accept.
- `DATA_VALID` input 1: request to send `P_DATA`.
- `PAR_TYP` input 1: 0 = even, 1 = odd (present only with `UART_TX_PARITY_EN`).
- `SER_DATA` input 1: current data bit from the `Serializer`.
- `SER_DONE` input 1: `Serializer` is presenting its last bit.
- `SER_EN` output 1: high for the whole DATA state.
- `SER_STEP` output 1: one-cycle pulse telling the `Serializer` to advance to the next bit.
- `SER_PDATA` output `DATA_WIDTH`: latched byte handed to the `Serializer`.
- `TX_OUT` output 1: serial line, idle high.
- `BUSY` output 1: frame in progress; `DATA_VALID` is ignored while high.
- `SER_ERR` output 1: sticky; the `Serializer` did not assert `SER_DONE` on data bit `DATA_WIDTH`. Cleared by reset only.

## Operation
- **States:** IDLE, START, DATA, PARITY (macro only), STOP.
- **Reset values:** state IDLE, `TX_OUT`=1, `BUSY`=0, `SER_EN`=0, `SER_STEP`=0, `SER_PDATA`=0, `SER_ERR`=0, baud counter 0, bit counter 0.
- **IDLE:**
  - `DATA_VALID`=1 latches `P_DATA` into `SER_PDATA` and latches `PAR_TYP`.
  - Parity is computed from the latched byte: even = XOR of all bits, odd = its inverse.
  - Go to START.
- **START:** `TX_OUT`=0 for one bit period, then go to DATA.
- **DATA:**
  - `SER_EN`=1 and `TX_OUT`=`SER_DATA`.
  - At the end of each bit period, `SER_STEP` pulses and the bit counter increments.
  - Exit after the `DATA_WIDTH`-th period. If `SER_DONE` was low at that boundary, set `SER_ERR` and exit anyway.
  - The bit counter overrides `SER_DONE`: an early `SER_DONE` does not end the frame.
- **PARITY:** `TX_OUT`=parity bit for one period, then go to STOP.
- **STOP:**
  - `TX_OUT`=1 for one period, then go to IDLE.
  - `BUSY` drops on the same edge the state returns to IDLE.
- **Back-to-back:** `DATA_VALID` held high across STOP end is accepted on the first IDLE cycle, giving one idle-high `CLK` cycle between frames.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1. It is cleared on accept and wraps at every bit boundary.
- **Reset mid-frame:** all outputs go to reset values asynchronously, the line returns high immediately, and the partial frame is abandoned.
- **Latched data:** `P_DATA` changes while `BUSY` have no effect.

## Timing
- `DATA_VALID` sampled high at edge N gives `BUSY`=1 and `TX_OUT`=0 after edge N (registered outputs, 1-cycle latency).
- Every bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length from accept to `BUSY` low:
  - (`DATA_WIDTH`+3)·`CLKS_PER_BIT` cycles with parity.
  - (`DATA_WIDTH`+2)·`CLKS_PER_BIT` cycles without.
- `SER_STEP` is high on the last cycle of each data bit period, `DATA_WIDTH` pulses per frame. The `Serializer` presents the new bit on the following cycle.
- `SER_EN` rises on the first cycle of DATA and falls on the first cycle after DATA.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - `PAR_TYP` port and PARITY state exist.
  - Parity is always sent.
  - Frame is 1 + `DATA_WIDTH` + 1 + 1 bits.
- **Not defined:**
  - No `PAR_TYP` port and no PARITY state.
  - DATA goes directly to STOP.
  - Frame is 1 + `DATA_WIDTH` + 1 bits.

## Structure
- Package `uart_tx_pkg`:
  - state enum `tx_state_e` (IDLE, START, DATA, PARITY, STOP).
  - Parity type constants `PAR_EVEN`=0, `PAR_ODD`=1.
  - Line level constants `LINE_IDLE`=1, `START_BIT`=0, `STOP_BIT`=1.
- Natural sub-module: `uart_baud_gen`, holding the `CLKS_PER_BIT` counter with clear input and a bit-boundary tick output.
- FSM, bit counter, parity and output mux stay in `uart_tx_ctrl`.

## Test plan
- **Reset mid-frame:** `RST` pulse during DATA bit 3 → `TX_OUT`=1 and `BUSY`=0 immediately; next `DATA_VALID` produces a clean full frame.
- **Basic frame, no parity:** `P_DATA`=8'hA5, `CLKS_PER_BIT`=4, `DATA_VALID` one cycle → `TX_OUT` shows 0, 1,0,1,0,0,1,0,1 (LSB first), 1, each bit 4 cycles; `BUSY` high 40 cycles; 8 `SER_STEP` pulses.
- **Parity:** with `UART_TX_PARITY_EN`, `P_DATA`=8'h07:
  - `PAR_TYP`=0 → parity bit 1, frame 44 cycles.
  - `PAR_TYP`=1 → parity bit 0.
- **Back-to-back and busy:**
  - `DATA_VALID` held high with 8'h00 then 8'hFF → two frames separated by exactly one idle-high cycle.
  - `P_DATA` changes while `BUSY` do not alter the frame in flight.
- **Serializer fault:** `SER_DONE` held low for the whole frame → `SER_ERR` rises at the end of the 8th data bit, the frame still completes with STOP, and `SER_ERR` stays high until `RST`.
